// File: rtl/wbcmd_burst.sv
// Command-to-wishbone burst bridge: sequenced requests run 1..2^CNT_W beats,
// and response bytes (header, read data, trailer) are queued in a byte FIFO.
module wbcmd_burst #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 8,
   parameter int SEQ_W      = 6,
   parameter int CNT_W      = 4,
   parameter int TIMEOUT    = 255,
   parameter int FIFO_DEPTH = 64
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            req_stb_i,
   input  logic [SEQ_W-1:0]                req_seq_i,
   input  logic                            req_we_i,
   input  logic                            req_inc_i,
   input  logic [CNT_W-1:0]                req_cnt_i,
   input  logic [ADDR_W-1:0]               req_adr_i,
   input  logic [DATA_W-1:0]               req_dat_i,
   output logic                            req_rdy_o,
   output logic                            wb_cyc_o,
   output logic                            wb_stb_o,
   output logic                            wb_we_o,
   output logic [ADDR_W-1:0]               wb_adr_o,
   output logic [DATA_W-1:0]               wb_dat_o,
   input  logic [DATA_W-1:0]               wb_dat_i,
   input  logic                            wb_ack_i,
   input  logic                            wb_err_i,
   output logic [7:0]                      resp_data,
   output logic [$clog2(FIFO_DEPTH):0]     resp_count,
   output logic                            resp_avail,
   input  logic                            resp_pull,
   output logic [1:0]                      dbg_state_o
);

   localparam int BYTES = DATA_W / 8;
   localparam int RES   = 2 + BYTES * (2 ** CNT_W);
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CW    = AW + 1;
   localparam int BW    = CNT_W + 1;
   localparam int TW    = $clog2(TIMEOUT + 1);
   localparam int IW    = (BYTES > 1) ? $clog2(BYTES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_BUS, S_PUSH, S_TRAIL} state_t;

   state_t              state_q;
   logic [SEQ_W-1:0]    recv_seq_q;
   logic                inc_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [BW-1:0]       beat_q;
   logic [TW-1:0]       to_q;
   logic                err_q;
   logic [DATA_W-1:0]   rdata_q;
   logic [IW-1:0]       bidx_q;
   logic                cyc_q, stb_q, we_q;
   logic [ADDR_W-1:0]   adr_q;
   logic [DATA_W-1:0]   dat_q;

   logic [7:0]          mem_q [FIFO_DEPTH];
   logic [AW-1:0]       wr_q, rd_q;
   logic [CW-1:0]       count_q, count_d;

   logic [CW-1:0]       free_w;
   logic                take_w, seq_ok_w, push_w, pull_w, last_beat_w;
   logic [7:0]          push_byte_w;
   logic [5:0]          acked_w;

   // Ready is gated by rst_n so it is low for the whole time reset is held.
   assign free_w      = CW'(FIFO_DEPTH) - count_q;
   assign req_rdy_o   = rst_n && (state_q == S_IDLE) && (int'(free_w) >= RES);
   assign take_w      = req_stb_i && req_rdy_o;
   assign seq_ok_w    = (req_seq_i == recv_seq_q);
   assign last_beat_w = (beat_q == BW'(cnt_q));
   assign acked_w     = 6'(beat_q);
   assign pull_w      = resp_pull && (count_q != '0);

   always_comb begin
      push_w      = 1'b0;
      push_byte_w = 8'h00;
      case (state_q)
         S_IDLE: begin
            if (take_w) begin
               push_w      = 1'b1;
               push_byte_w = seq_ok_w ? {2'b00, 6'(req_seq_i)} : {2'b10, 6'(recv_seq_q)};
            end
         end
         S_PUSH: begin
            push_w      = 1'b1;
            push_byte_w = rdata_q[8*bidx_q +: 8];
         end
         S_TRAIL: begin
            push_w      = 1'b1;
            push_byte_w = {err_q, 1'b0, acked_w};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         recv_seq_q <= '0;
         inc_q      <= 1'b0;
         cnt_q      <= '0;
         beat_q     <= '0;
         to_q       <= '0;
         err_q      <= 1'b0;
         rdata_q    <= '0;
         bidx_q     <= '0;
         cyc_q      <= 1'b0;
         stb_q      <= 1'b0;
         we_q       <= 1'b0;
         adr_q      <= '0;
         dat_q      <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (take_w && seq_ok_w) begin
                  recv_seq_q <= recv_seq_q + 1'b1;
                  we_q       <= req_we_i;
                  inc_q      <= req_inc_i;
                  cnt_q      <= req_cnt_i;
                  dat_q      <= req_dat_i;
                  adr_q      <= req_adr_i;
                  beat_q     <= '0;
                  to_q       <= '0;
                  err_q      <= 1'b0;
                  bidx_q     <= '0;
                  cyc_q      <= 1'b1;
                  stb_q      <= 1'b1;
                  state_q    <= S_BUS;
               end
            end
            S_BUS: begin
               // err wins over a simultaneous ack; the failed beat is not counted
               if (wb_err_i || (!wb_ack_i && to_q == TW'(TIMEOUT - 1))) begin
                  stb_q   <= 1'b0;
                  cyc_q   <= 1'b0;
                  err_q   <= 1'b1;
                  state_q <= S_TRAIL;
               end else if (wb_ack_i) begin
                  beat_q <= beat_q + 1'b1;
                  to_q   <= '0;
                  if (!we_q) begin
                     rdata_q <= wb_dat_i;
                     stb_q   <= 1'b0;
                     bidx_q  <= '0;
                     cyc_q   <= !last_beat_w;
                     state_q <= S_PUSH;
                  end else if (last_beat_w) begin
                     stb_q   <= 1'b0;
                     cyc_q   <= 1'b0;
                     state_q <= S_TRAIL;
                  end else if (inc_q) begin
                     adr_q <= adr_q + 1'b1;
                  end
               end else begin
                  to_q <= to_q + 1'b1;
               end
            end
            S_PUSH: begin
               bidx_q <= bidx_q + 1'b1;
               if (bidx_q == IW'(BYTES - 1)) begin
                  bidx_q <= '0;
                  if (beat_q != BW'(cnt_q) + BW'(1)) begin
                     stb_q   <= 1'b1;
                     state_q <= S_BUS;
                     if (inc_q) adr_q <= adr_q + 1'b1;
                  end else begin
                     state_q <= S_TRAIL;
                  end
               end
            end
            S_TRAIL: state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign count_d = count_q + CW'(push_w) - CW'(pull_w);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (push_w) wr_q <= wr_q + 1'b1;
         if (pull_w) rd_q <= rd_q + 1'b1;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_w) mem_q[wr_q] <= push_byte_w;
   end

   assign resp_data   = (count_q != '0) ? mem_q[rd_q] : 8'h00;
   assign resp_count  = count_q;
   assign resp_avail  = (count_q != '0);
   assign wb_cyc_o    = cyc_q;
   assign wb_stb_o    = stb_q;
   assign wb_we_o     = we_q;
   assign wb_adr_o    = adr_q;
   assign wb_dat_o    = dat_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wbcmd_burst.sv
// Bench for wbcmd_burst: 32-bit bus, 4-beat max bursts, 32-byte FIFO, 8-cycle timeout.
module tb_wbcmd_burst;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_stb_i = 1'b0;
   logic [2:0]  req_seq_i = '0;
   logic        req_we_i = 1'b0;
   logic        req_inc_i = 1'b0;
   logic [1:0]  req_cnt_i = '0;
   logic [15:0] req_adr_i = '0;
   logic [31:0] req_dat_i = '0;
   logic        req_rdy_o;
   logic        wb_cyc_o, wb_stb_o, wb_we_o;
   logic [15:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [31:0] wb_dat_i = '0;
   logic        wb_ack_i = 1'b0;
   logic        wb_err_i = 1'b0;
   logic [7:0]  resp_data;
   logic [5:0]  resp_count;
   logic        resp_avail;
   logic        resp_pull = 1'b0;
   logic [1:0]  dbg_state_o;

   wbcmd_burst #(
      .ADDR_W(16), .DATA_W(32), .SEQ_W(3), .CNT_W(2), .TIMEOUT(8), .FIFO_DEPTH(32)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_stb_i(req_stb_i), .req_seq_i(req_seq_i), .req_we_i(req_we_i),
      .req_inc_i(req_inc_i), .req_cnt_i(req_cnt_i), .req_adr_i(req_adr_i),
      .req_dat_i(req_dat_i), .req_rdy_o(req_rdy_o),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
      .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
      .resp_data(resp_data), .resp_count(resp_count), .resp_avail(resp_avail),
      .resp_pull(resp_pull), .dbg_state_o(dbg_state_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  seq;
      logic        we;
      logic        inc;
      logic [1:0]  cnt;
      logic [15:0] adr;
      logic [31:0] dat;
      logic [7:0]  dly;       // cycles of stb before the slave answers; FF = never
      int          err_beat;  // beat index answered with err; 7 = none
      logic [7:0]  exp_trl;
      int          exp_cyc;   // cycles with wb_cyc_o high
      int          exp_nadr;  // beats answered by the slave (ack or err)
   } vec_t;

   int          n_chk = 0;
   int          n_pass = 0;
   logic [7:0]  exp_q[$];

   // slave model state
   logic [7:0]  sl_dly = 8'h00;
   int          sl_err_beat = 7;
   logic        cur_we = 1'b0;
   logic [31:0] cur_dat = '0;
   int          sl_wait = 0;
   int          sl_beat = 0;
   int          cyc_total = 0;
   int          bus_bad = 0;
   logic [15:0] adr_log[$];

   function automatic logic [31:0] slave_data(input int b);
      return 32'h11223344 + 32'(b) * 32'h11111111;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   always @(negedge clk) begin
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      if (wb_cyc_o) begin
         cyc_total++;
         if (wb_we_o !== cur_we || wb_dat_o !== cur_dat) bus_bad++;
      end else begin
         sl_beat = 0;
      end
      if (wb_cyc_o && wb_stb_o) begin
         if (sl_wait == int'(sl_dly)) begin
            adr_log.push_back(wb_adr_o);
            if (sl_beat == sl_err_beat) wb_err_i = 1'b1;
            else begin
               wb_ack_i = 1'b1;
               wb_dat_i = slave_data(sl_beat);
            end
            sl_beat++;
            sl_wait = 0;
         end else begin
            sl_wait++;
         end
      end else begin
         sl_wait = 0;
      end
   end

   task automatic do_req(input vec_t v);
      int a0, c0, b0, n;
      logic [31:0] d;
      logic [15:0] ea;
      sl_dly = v.dly; sl_err_beat = v.err_beat; cur_we = v.we; cur_dat = v.dat;
      a0 = adr_log.size(); c0 = cyc_total; b0 = bus_bad;
      chk("req_rdy_before", 32'(req_rdy_o), 32'd1);
      req_seq_i = v.seq; req_we_i = v.we; req_inc_i = v.inc; req_cnt_i = v.cnt;
      req_adr_i = v.adr; req_dat_i = v.dat; req_stb_i = 1'b1;
      @(negedge clk);
      req_stb_i = 1'b0;
      n = 0;
      while (!(dbg_state_o == 2'd0 && !wb_cyc_o) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("burst_done", 32'(n < 200), 32'd1);
      chk("cyc_cycles", 32'(cyc_total - c0), 32'(v.exp_cyc));
      chk("beats_seen", 32'(adr_log.size() - a0), 32'(v.exp_nadr));
      for (int i = 0; i < v.exp_nadr && (a0 + i) < adr_log.size(); i++) begin
         ea = v.adr + (v.inc ? 16'(i) : 16'h0);
         chk("wb_adr", 32'(adr_log[a0+i]), 32'(ea));
      end
      chk("we_dat_stable", 32'(bus_bad - b0), 32'd0);
      exp_q.push_back({5'b0, v.seq});
      if (!v.we) begin
         for (int b = 0; b < int'(v.exp_trl[5:0]); b++) begin
            d = slave_data(b);
            for (int k = 0; k < 4; k++) exp_q.push_back(d[8*k +: 8]);
         end
      end
      exp_q.push_back(v.exp_trl);
   endtask

   task automatic pull_one();
      logic [7:0] e;
      e = exp_q.pop_front();
      chk("resp_byte", 32'(resp_data), 32'(e));
      resp_pull = 1'b1;
      @(negedge clk);
      resp_pull = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (resp_avail && exp_q.size() != 0 && n < 64) begin
         pull_one();
         n++;
      end
      chk("exp_left", 32'(exp_q.size()), 32'd0);
      chk("fifo_left", 32'(resp_count), 32'd0);
   endtask

   task automatic strobe(input logic [2:0] seq);
      req_seq_i = seq; req_stb_i = 1'b1;
      @(negedge clk);
      req_stb_i = 1'b0;
   endtask

   vec_t vecs[6];
   vec_t fill_v, post_v;

   initial begin
      vecs[0] = '{3'd0, 1'b0, 1'b0, 2'd0, 16'h1234, 32'h0,  8'd2,   7, 8'h01, 3,  1};
      vecs[1] = '{3'd1, 1'b0, 1'b1, 2'd2, 16'h0010, 32'h0,  8'd1,   7, 8'h03, 14, 3};
      vecs[2] = '{3'd2, 1'b1, 1'b0, 2'd3, 16'h0200, 32'hA5, 8'd0,   7, 8'h04, 4,  4};
      vecs[3] = '{3'd3, 1'b0, 1'b1, 2'd1, 16'hFFFF, 32'h0,  8'd0,   1, 8'h81, 6,  2};
      vecs[4] = '{3'd4, 1'b0, 1'b0, 2'd0, 16'h0300, 32'h0,  8'hFF,  7, 8'h80, 8,  0};
      vecs[5] = '{3'd5, 1'b1, 1'b1, 2'd0, 16'h0ABC, 32'h3C, 8'd0,   7, 8'h01, 1,  1};
      fill_v  = '{3'd6, 1'b0, 1'b0, 2'd3, 16'h0040, 32'h0,  8'd0,   7, 8'h04, 16, 4};
      post_v  = '{3'd0, 1'b1, 1'b1, 2'd1, 16'h0500, 32'h5A, 8'd0,   7, 8'h02, 2,  2};

      // reset values while rst_n is held low
      #12;
      chk("rst_rdy", 32'(req_rdy_o), 32'd0);
      chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
      chk("rst_stb", 32'(wb_stb_o), 32'd0);
      chk("rst_adr", 32'(wb_adr_o), 32'd0);
      chk("rst_count", 32'(resp_count), 32'd0);
      chk("rst_avail", 32'(resp_avail), 32'd0);
      chk("rst_data", 32'(resp_data), 32'd0);
      chk("rst_state", 32'(dbg_state_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         do_req(vecs[i]);
         drain();
      end

      // wrong sequence: recv_seq is 6, request 1 -> single nak byte
      strobe(3'd1);
      exp_q.push_back(8'h86);
      chk("nak_state", 32'(dbg_state_o), 32'd0);
      chk("nak_cyc", 32'(wb_cyc_o), 32'd0);
      chk("nak_count", 32'(resp_count), 32'd1);
      drain();

      // host stops pulling: 18 bytes leave less free space than one reservation
      do_req(fill_v);
      chk("fill_count", 32'(resp_count), 32'd18);
      chk("fill_rdy", 32'(req_rdy_o), 32'd0);
      strobe(3'd0);
      chk("ign_nak_count", 32'(resp_count), 32'd18);
      strobe(3'd7);
      chk("ign_acc_count", 32'(resp_count), 32'd18);
      chk("ign_acc_state", 32'(dbg_state_o), 32'd0);
      chk("ign_acc_cyc", 32'(wb_cyc_o), 32'd0);
      repeat (3) pull_one();
      chk("rdy_at_15", 32'(req_rdy_o), 32'd0);
      pull_one();
      chk("rdy_at_14", 32'(req_rdy_o), 32'd1);
      // nak push and pull in the same cycle leave the occupancy unchanged
      req_seq_i = 3'd0; req_stb_i = 1'b1;
      pull_one();
      req_stb_i = 1'b0;
      exp_q.push_back(8'h87);
      chk("push_pull_count", 32'(resp_count), 32'd14);
      drain();

      // reset in the middle of a burst the slave never answers
      sl_dly = 8'hFF; sl_err_beat = 7; cur_we = 1'b0; cur_dat = '0;
      req_we_i = 1'b0; req_inc_i = 1'b0; req_cnt_i = 2'd3; req_adr_i = 16'h0100; req_dat_i = '0;
      strobe(3'd7);
      repeat (2) @(negedge clk);
      chk("mid_cyc", 32'(wb_cyc_o), 32'd1);
      chk("mid_count", 32'(resp_count), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_cyc", 32'(wb_cyc_o), 32'd0);
      chk("arst_stb", 32'(wb_stb_o), 32'd0);
      chk("arst_count", 32'(resp_count), 32'd0);
      chk("arst_avail", 32'(resp_avail), 32'd0);
      chk("arst_rdy", 32'(req_rdy_o), 32'd0);
      chk("arst_state", 32'(dbg_state_o), 32'd0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      // recv_seq restarted at 0
      do_req(post_v);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/wbcmd_burst.md
Name: wbcmd_burst

Overview:
- Parametrised successor of the single-beat command-to-wishbone bridge.
- Accepts sequenced requests from the command parser and runs 1..2^CNT_W wishbone beats per request, with fixed or incrementing address.
- Bus width is configurable; a per-beat timeout and wb error both terminate the burst.
- Response bytes go through an internal byte FIFO to the response serializer, so the bus is not stalled by a slow host link.

Parameters:
ADDR_W, 16, wishbone address width
DATA_W, 8, wishbone data width; 8, 16 or 32
SEQ_W, 6, request sequence width; 1..6
CNT_W, 4, burst length field width; 1..6
TIMEOUT, 255, cycles without ack/err before a beat is aborted; >=1
FIFO_DEPTH, 64, response FIFO bytes; power of 2; >= 2 + (DATA_W/8)*2^CNT_W

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_stb_i  in  1  request strobe, one cycle per request
req_seq_i  in  SEQ_W  request sequence
req_we_i  in  1  1=write, 0=read
req_inc_i  in  1  1=increment address per beat, 0=fixed address
req_cnt_i  in  CNT_W  beats minus one
req_adr_i  in  ADDR_W  start address
req_dat_i  in  DATA_W  write data, used for every write beat
req_rdy_o  out  1  request accepted/naked only when high
wb_cyc_o, wb_stb_o, wb_we_o  out  1  wishbone controls
wb_adr_o  out  ADDR_W  wishbone address
wb_dat_o  out  DATA_W  wishbone write data
wb_dat_i  in  DATA_W  wishbone read data
wb_ack_i, wb_err_i  in  1  wishbone termination
resp_data  out  8  FIFO head byte, show-ahead
resp_count  out  clog2(FIFO_DEPTH)+1  FIFO occupancy in bytes
resp_avail  out  1  resp_count != 0
resp_pull  in  1  pop head byte; ignored when empty

Behaviour:
- Reset (async, rst_n low): state IDLE, recv_seq=0, FIFO empty, all wb outputs 0, resp_avail=0, resp_count=0, resp_data=0, req_rdy_o=0 while rst_n low. Reset mid-burst drops the cycle immediately; partial responses are discarded.
- req_rdy_o = state IDLE && free >= 2+(DATA_W/8)*2^CNT_W. req_stb_i while !req_rdy_o is ignored: no nak, no seq change.
- Nak: req_stb_i && req_rdy_o && req_seq_i != recv_seq pushes one byte {1,0,recv_seq zero-extended to 6b}. State unchanged.
- Accept: req_stb_i && req_rdy_o && seq match.
  - Pushes header {0,0,req_seq_i ext}.
  - recv_seq+1, wrapping mod 2^SEQ_W.
  - Latches we/inc/cnt/dat, beat counter=0, timeout counter=0.
  - Next cycle: wb_cyc_o=wb_stb_o=1, wb_adr_o=req_adr_i. State goes to BUS.
- BUS:
  - wb_stb_o=1; timeout counter increments each cycle without ack/err.
  - ack, read: capture wb_dat_i, stb=0, go PUSH.
  - ack, write, more beats: stb stays 1; adr+1 if inc (wraps mod 2^ADDR_W); counter cleared.
  - ack, write, last beat: go TRAIL.
  - wb_err_i, or counter reaching TIMEOUT with no ack: stb=0, err flag set, remaining beats skipped, go TRAIL. ack and err on the same cycle counts as err.
- PUSH: pushes DATA_W/8 bytes, one per cycle, least-significant byte first. Then:
  - more beats: go BUS, stb=1, adr advanced if inc;
  - otherwise: go TRAIL.
- TRAIL:
  - Pushes one byte {err,0,beats_acked[5:0]}; beats_acked excludes the failed beat.
  - wb_cyc_o=0 from the next cycle; state goes to IDLE.
  - wb_cyc_o stays 1 from the accept+1 cycle through the last ack/err/timeout cycle.
- FIFO:
  - A push and a pull in the same cycle both take effect; occupancy is unchanged.
  - A push never occurs when full, guaranteed by the req_rdy_o reservation.
  - resp_data is the head byte; it updates in the cycle after a pull.
- wb_we_o and wb_dat_o stay constant for the whole burst.

Test Plan:
- DATA_W=8, seq 0, read cnt=0, adr 0x1234, slave ack after 2 cycles with 0x5A -> FIFO gets 0x00, 0x5A, 0x01; recv_seq=1; cyc high exactly from accept+1 until ack.
- DATA_W=32, read cnt=2, inc=1, adr 0x0010, data 0x11223344/… -> addresses 0x10, 0x11, 0x12; 14 bytes: header, 0x44 0x33 0x22 0x11 …, trailer 0x03.
- Write cnt=3, inc=0, dat 0xA5, ack every cycle -> 4 back-to-back stb cycles at the same address; bytes: header, trailer 0x04.
- Slave never acks, TIMEOUT=8 -> stb drops 8 cycles after assertion; trailer 0x80; next request with seq+1 accepted.
- Wrong seq (recv_seq=3, req 5) -> single byte 0x83; recv_seq unchanged. Repeat with req_rdy_o low -> no byte pushed.
- Host never pulls -> req_rdy_o falls once free space < reservation. Assert rst_n low mid-burst -> cyc/stb drop asynchronously, resp_count=0, recv_seq=0.
